// File: rtl/wbu_pkg.sv
// wbu_pkg: shared types and constants for the write-back stage.
// Holds write-back select codes, FSM state encodings and datapath defaults.
// Imported by wbu and wbu_reg_file.
package wbu_pkg;

  localparam int WBU_XLEN   = 32;
  localparam int WBU_NR_REG = 32;

  // Write-back value source
  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;
  localparam logic [1:0] WBSEL_CSR = 2'd3;

  // Encoding 2'd3 is illegal and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_WAIT_READY = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/wbu_reg_file.sv
// wbu_reg_file: NR_REG x XLEN general purpose register file, x0 hardwired to zero.
// Latency: write lands at the clock edge, reads are combinational with no bypass.
// Backpressure: none; the write port is a single-cycle strobe.
module wbu_reg_file
  import wbu_pkg::*;
#(
  parameter int XLEN   = WBU_XLEN,
  parameter int NR_REG = WBU_NR_REG,
  parameter int AW     = $clog2(NR_REG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            wen,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] regs_q [NR_REG];

  // Storage: reset clears every register; writes to x0 are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports: x0 forced to zero independent of storage contents
  assign rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];

endmodule

// File: rtl/wbu.sv
// wbu: write-back stage; captures a retiring instruction, commits it to the GPRs, hands dnpc to the IFU.
// Latency: capture in IDLE, GPR write at the end of WRITE, m_valid in WAIT_READY (3 cycles minimum per instruction).
// Backpressure: s_ready only in IDLE; WAIT_READY holds dnpcW until m_ready. Macro WBU_INSTRET_EN adds instret/commit.
module wbu
  import wbu_pkg::*;
#(
  parameter int XLEN   = WBU_XLEN,
  parameter int NR_REG = WBU_NR_REG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALU_resultX,
  input  logic [XLEN-1:0] mdataM,
  input  logic [XLEN-1:0] csr_rdataX,
  input  logic [XLEN-1:0] pcX,
  input  logic [XLEN-1:0] dnpcX,
  input  logic [4:0]      rdX,
  input  logic            rwenX,
  input  logic [1:0]      wbselX,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [XLEN-1:0] dnpcW,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
`ifdef WBU_INSTRET_EN
  ,
  output logic [63:0]     instret,
  output logic            commit
`endif
);

  wbu_state_e      state_q, state_d;
  logic            s_ready_q, m_valid_q;
  logic            capture;

  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] mdata_q, mdata_d;
  logic [XLEN-1:0] csr_rdata_q, csr_rdata_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] dnpc_q, dnpc_d;
  logic [4:0]      rd_q, rd_d;
  logic            rwen_q, rwen_d;
  logic [1:0]      wbsel_q, wbsel_d;

  logic [XLEN-1:0] wb_dat;
  logic            gpr_wen;

  assign capture = (state_q == ST_IDLE) && s_valid;

  // Next-state logic; illegal encodings fall back to IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:       state_d = s_valid ? ST_WRITE : ST_IDLE;
      ST_WRITE:      state_d = ST_WAIT_READY;
      ST_WAIT_READY: state_d = m_ready ? ST_IDLE : ST_WAIT_READY;
      default:       state_d = ST_IDLE;
    endcase
  end

  // FSM state with handshake outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == ST_IDLE);
      m_valid_q <= (state_d == ST_WAIT_READY);
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;

  // Instruction capture: load on the IDLE handshake, hold otherwise
  always_comb begin
    alu_result_d = alu_result_q;
    mdata_d      = mdata_q;
    csr_rdata_d  = csr_rdata_q;
    pc_d         = pc_q;
    dnpc_d       = dnpc_q;
    rd_d         = rd_q;
    rwen_d       = rwen_q;
    wbsel_d      = wbsel_q;
    if (capture) begin
      alu_result_d = ALU_resultX;
      mdata_d      = mdataM;
      csr_rdata_d  = csr_rdataX;
      pc_d         = pcX;
      dnpc_d       = dnpcX;
      rd_d         = rdX;
      rwen_d       = rwenX;
      wbsel_d      = wbselX;
    end
  end

  // W registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q <= '0;
      mdata_q      <= '0;
      csr_rdata_q  <= '0;
      pc_q         <= '0;
      dnpc_q       <= '0;
      rd_q         <= '0;
      rwen_q       <= 1'b0;
      wbsel_q      <= WBSEL_ALU;
    end else begin
      alu_result_q <= alu_result_d;
      mdata_q      <= mdata_d;
      csr_rdata_q  <= csr_rdata_d;
      pc_q         <= pc_d;
      dnpc_q       <= dnpc_d;
      rd_q         <= rd_d;
      rwen_q       <= rwen_d;
      wbsel_q      <= wbsel_d;
    end
  end

  assign dnpcW = dnpc_q;

  // Write-back source select; PC+4 wraps modulo 2^XLEN
  always_comb begin
    wb_dat = alu_result_q;
    case (wbsel_q)
      WBSEL_ALU: wb_dat = alu_result_q;
      WBSEL_MEM: wb_dat = mdata_q;
      WBSEL_PC4: wb_dat = pc_q + XLEN'(4);
      WBSEL_CSR: wb_dat = csr_rdata_q;
      default:   wb_dat = alu_result_q;
    endcase
  end

  // Commit strobe is only live during WRITE, so it lands on the edge ending WRITE
  assign gpr_wen = (state_q == ST_WRITE) && rwen_q && (rd_q != 5'd0);

  wbu_reg_file #(
    .XLEN   (XLEN),
    .NR_REG (NR_REG),
    .AW     (5)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .waddr    (rd_q),
    .wdata    (wb_dat),
    .wen      (gpr_wen),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

`ifdef WBU_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  assign commit = m_valid_q && m_ready;

  // Retired-instruction count, one per IFU handshake, wraps at 2^64
  always_comb begin
    instret_d = instret_q;
    if (commit) begin
      instret_d = instret_q + 64'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed-vector bench for the write-back stage.
// Drives inputs and samples outputs on the falling edge; expected values are hand-computed.
// Optional instret/commit checks are compiled in with WBU_INSTRET_EN.
module tb_wbu;

  logic        clk;
  logic        rst;
  logic [31:0] ALU_resultX, mdataM, csr_rdataX, pcX, dnpcX;
  logic [4:0]  rdX;
  logic        rwenX;
  logic [1:0]  wbselX;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] dnpcW;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
`ifdef WBU_INSTRET_EN
  logic [63:0] instret;
  logic        commit;
  int          commit_cnt = 0;
  int          commit_base;
`endif

  int n_cmp = 0;
  int n_err = 0;
  longint exp_instret = 0;

  wbu dut (
    .clk         (clk),
    .rst         (rst),
    .ALU_resultX (ALU_resultX),
    .mdataM      (mdataM),
    .csr_rdataX  (csr_rdataX),
    .pcX         (pcX),
    .dnpcX       (dnpcX),
    .rdX         (rdX),
    .rwenX       (rwenX),
    .wbselX      (wbselX),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .dnpcW       (dnpcW),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data)
`ifdef WBU_INSTRET_EN
    ,
    .instret     (instret),
    .commit      (commit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WBU_INSTRET_EN
  always @(posedge clk) begin
    if (commit) commit_cnt++;
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] mdata, input logic [31:0] csr,
                       input logic [31:0] pc, input logic [31:0] dnpc, input logic [4:0] rd,
                       input logic rwen, input logic [1:0] wbsel);
    ALU_resultX = alu;
    mdataM      = mdata;
    csr_rdataX  = csr;
    pcX         = pc;
    dnpcX       = dnpc;
    rdX         = rd;
    rwenX       = rwen;
    wbselX      = wbsel;
  endtask

  // Present s_valid until accepted; returns at the falling edge inside WRITE
  task automatic issue(input string tag);
    s_valid = 1'b1;
    for (int k = 0; k < 20 && !s_ready; k++) @(negedge clk);
    check({tag, "_srdy_idle"}, s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    check({tag, "_srdy_write"}, s_ready, 0);
  endtask

  task automatic retire();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_instret++;
  endtask

  // Full instruction: issue, expect m_valid exactly one cycle after WRITE, handshake
  task automatic run(input string tag, input logic [31:0] dnpc_exp);
    issue(tag);
    @(negedge clk);
    check({tag, "_mvalid"}, m_valid, 1);
    check({tag, "_dnpcW"}, dnpcW, dnpc_exp);
    retire();
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    rs1_addr = addr;
    rs2_addr = addr;
    #1;
    check({tag, "_rs1"}, rs1_data, exp);
    check({tag, "_rs2"}, rs2_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0);

    // Reset state
    @(negedge clk);
    check("rst_srdy", s_ready, 1);
    check("rst_mvalid", m_valid, 0);
    check("rst_dnpcW", dnpcW, 32'h0);
    rd_chk("rst_x5", 5'd5, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ALU write to x5: WRITE-cycle read still sees the old value
    drive(32'h1234, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0004, 5'd5, 1'b1, 2'd0);
    rs1_addr = 5'd5;
    issue("alu");
    #1 check("alu_nobypass", rs1_data, 32'h0);
    check("alu_mvalid_write", m_valid, 0);
    @(negedge clk);
    check("alu_mvalid", m_valid, 1);
    check("alu_dnpcW", dnpcW, 32'h8000_0004);
    rd_chk("alu_x5", 5'd5, 32'h1234);
    retire();
    check("alu_srdy_back", s_ready, 1);
    check("alu_mvalid_back", m_valid, 0);

    // x0 is never written
    drive(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h10, 32'h14, 5'd0, 1'b1, 2'd0);
    run("x0", 32'h14);
    rd_chk("x0_zero", 5'd0, 32'h0);
    rd_chk("x0_x5kept", 5'd5, 32'h1234);

    // CSR to x1, then PC+4 wrap overwrites x1 with zero
    drive(32'h1111, 32'h2222, 32'h3333, 32'h20, 32'h24, 5'd1, 1'b1, 2'd3);
    run("csr", 32'h24);
    rd_chk("csr_x1", 5'd1, 32'h3333);
    drive(32'h1111, 32'h2222, 32'h3333, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1, 2'd2);
    run("pc4wrap", 32'h0);
    rd_chk("pc4wrap_x1", 5'd1, 32'h0);
    drive(32'h1111, 32'h2222, 32'h3333, 32'h100, 32'h104, 5'd3, 1'b1, 2'd2);
    run("pc4", 32'h104);
    rd_chk("pc4_x3", 5'd3, 32'h104);

    // Load data to x2
    drive(32'h1, 32'hFFFF_FF80, 32'h3, 32'h30, 32'h34, 5'd2, 1'b1, 2'd1);
    run("mem", 32'h34);
    rd_chk("mem_x2", 5'd2, 32'hFFFF_FF80);

    // Backpressure: IFU stalls 5 cycles while upstream already offers the next instruction
    drive(32'hA5, 32'h0, 32'h0, 32'h1FC, 32'h200, 5'd4, 1'b1, 2'd0);
    issue("hold");
    @(negedge clk);
    drive(32'h66, 32'h0, 32'h0, 32'h2FC, 32'h300, 5'd6, 1'b1, 2'd0);
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_mvalid", m_valid, 1);
      check("hold_dnpcW", dnpcW, 32'h200);
      check("hold_srdy", s_ready, 0);
      @(negedge clk);
    end
    check("hold_mvalid_end", m_valid, 1);
    retire();
    check("hold_idle_srdy", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    check("hold_recap_srdy", s_ready, 0);
    rd_chk("hold_x4", 5'd4, 32'hA5);
    @(negedge clk);
    check("hold_recap_mvalid", m_valid, 1);
    check("hold_recap_dnpcW", dnpcW, 32'h300);
    retire();
    rd_chk("hold_x6", 5'd6, 32'h66);

    // rwen=0 still retires but leaves x5 alone
    drive(32'h9999, 32'h0, 32'h0, 32'h40, 32'h44, 5'd5, 1'b0, 2'd0);
    run("norwen", 32'h44);
    rd_chk("norwen_x5", 5'd5, 32'h1234);
`ifdef WBU_INSTRET_EN
    check("instret_pre_rst", instret, exp_instret);
`endif

    // Asynchronous reset in WRITE aborts the write
    drive(32'h55, 32'h0, 32'h0, 32'h50, 32'h54, 5'd7, 1'b1, 2'd0);
    issue("rstw");
    #1 rst = 1'b1;
    #1;
    check("rstw_srdy", s_ready, 1);
    check("rstw_mvalid", m_valid, 0);
    check("rstw_dnpcW", dnpcW, 32'h0);
    rd_chk("rstw_x7", 5'd7, 32'h0);
    rd_chk("rstw_x5", 5'd5, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_instret = 0;
    @(negedge clk);
    check("rstw_mvalid_after", m_valid, 0);
    rd_chk("rstw_x7_after", 5'd7, 32'h0);
`ifdef WBU_INSTRET_EN
    check("rstw_instret", instret, 64'd0);
    commit_base = commit_cnt;
`endif

    // Three back-to-back instructions
    drive(32'h11, 32'h0, 32'h0, 32'h60, 32'h64, 5'd8, 1'b1, 2'd0);
    run("b2b0", 32'h64);
    drive(32'h22, 32'h0, 32'h0, 32'h64, 32'h68, 5'd9, 1'b0, 2'd0);
    run("b2b1", 32'h68);
    drive(32'h0, 32'h33, 32'h0, 32'h68, 32'h6C, 5'd10, 1'b1, 2'd1);
    run("b2b2", 32'h6C);
    rd_chk("b2b_x8", 5'd8, 32'h11);
    rd_chk("b2b_x9", 5'd9, 32'h0);
    rd_chk("b2b_x10", 5'd10, 32'h33);
`ifdef WBU_INSTRET_EN
    check("b2b_instret", instret, 64'd3);
    check("b2b_commit_cnt", 64'(commit_cnt - commit_base), 64'd3);
    check("b2b_instret_model", instret, exp_instret);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
